updown_counter_display: RTL
===========================

// Module: updown_counter_display
// PURPOSE
//  Parametrised multi-digit up/down counter with BCD/hex mode, selectable count rate,
//  parallel load and wrap flag, driving a multiplexed active-low 8-digit seven-segment display.
//  Next-generation board-level counter for lab top levels: sits between switches/buttons and the
//  display pins.
// PARAMETERS
//  DIGITS      8   counted and displayed digits, 1..8
//  PRESCALE_W  27  width of free-running rate divider; speed selects a tap of it
//  SCAN_BIT    17  display advances one digit every 2^SCAN_BIT clocks (>=1)
// PORTS
//  clk       in   1          system clock
//  rst       in   1          synchronous, active-high reset
//  enable    in   1          1 = count on rate ticks; 0 = hold (display keeps scanning)
//  upDown    in   1          1 = count up, 0 = count down
//  BCDHex    in   1          0 = BCD (base 10), 1 = hex (base 16)
//  speed     in   5          divider tap index; rate tick on rising edge of div[speed]
//  load      in   1          synchronous parallel load of load_val
//  load_val  in   4*DIGITS   load value, digit 0 in [3:0]
//  count     out  4*DIGITS   current count, digit 0 in [3:0]
//  wrap      out  1          one-cycle pulse on full-range wrap (max->0 up, 0->max down)
//  cc        out  7          segments {g,f,e,d,c,b,a}, active-low
//  an        out  8          digit anodes, active-low, one-hot-low
//  odp       out  1          decimal point, active-low
// BEHAVIOUR
//  Reset: div=0, prev tap=0, count=0, scan index=0, wrap=0, an=8'hFE, cc=7'b1000000 ("0"),
//   odp=1. Applies in any state, including mid-count or mid-load.
//  Rate: div increments every clk and wraps at 2^PRESCALE_W. Effective tap = min(speed, PRESCALE_W-1).
//   tick = tap bit is 1 now and was 0 last cycle (registered edge detect).
//   speed=0 -> tick every 2 clks; speed=k -> every 2^(k+1) clks.
//   A speed change mid-run must not produce more than one tick in a single cycle.
//  Count priority per clk: rst > load > mode change > (tick & enable) > hold.
//   Load: count <= load_val. In BCD mode any digit >9 is stored as 9. No wrap pulse.
//   Mode change: BCDHex differs from its registered copy -> count <= 0 next clk. No wrap pulse.
//    This clear beats a same-cycle tick; a same-cycle load still wins.
//   Up: digit0 +1. A digit at B-1 (B = 10 or 16) becomes 0 and carries into the next digit.
//    All digits at B-1 -> all 0 and wrap=1 for that cycle.
//   Down: digit0 -1. A digit at 0 becomes B-1 and borrows from the next digit.
//    All 0 -> all B-1 and wrap=1.
//   upDown and enable are sampled on the tick cycle only; a change between ticks takes effect
//    at the next tick.
//  Count update latency: 1 clk after the qualifying cycle. count is a direct register output.
//  Display: scan counter free-runs. Index advances 0..DIGITS-1 then wraps to 0, one step per
//   2^SCAN_BIT clks.
//   an[index]=0, all other bits 1. Bits >= DIGITS are always 1.
//   cc = hex font of count digit[index] (0-9, A b C d E F). Only digits 0-9 occur in BCD mode.
//   odp=0 only when index==0 and upDown==0 (down indicator); otherwise 1.
//   cc/an/odp are registered: they follow an index or count change by 1 clk.
//   They update even while enable=0.
// TESTING
//  (bench: DIGITS=4, PRESCALE_W=8, SCAN_BIT=2)
//  1 Reset: rst=1 for 5 clks, then 0 -> count=0, wrap=0, an=8'hFE, cc=7'b1000000, odp=1.
//  2 Rate: speed=0, enable=1, up, BCD -> count +1 every 2 clks; speed=2 -> every 8 clks;
//    speed=31 clamps to tap 7 -> every 256 clks.
//  3 BCD wrap up: load 16'h9998, tick x2 -> 9999 then 0000 with one-cycle wrap=1;
//    load 16'h0000, down -> 9999 with wrap=1.
//  4 Hex carry: BCDHex=1, load 16'h00FF, up tick -> 0100, no wrap;
//    load 16'h00AF in BCD mode -> stored 16'h0099.
//  5 Simultaneous events: load with tick same cycle -> load_val, no increment;
//    BCDHex toggles with tick -> count 0; rst asserted mid-run -> all reset values next clk.
//  6 Display scan: count 16'h1234 -> an cycles FE,FD,FB,F7 every 4 clks, then back to FE;
//    cc shows 4,3,2,1; odp=0 only on FE while upDown=0; an[7:4] stay 1.

Source files
------------

// File: rtl/updown_counter_display_if.sv
// Switch/button inputs and counter/display outputs of the up/down counter.
interface updown_counter_display_if #(
    parameter int unsigned DIGITS = 8
);
    localparam int unsigned CW = 4 * DIGITS;

    logic          enable;
    logic          upDown;
    logic          BCDHex;
    logic [4:0]    speed;
    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          wrap;
    logic [6:0]    cc;
    logic [7:0]    an;
    logic          odp;

    modport master (
        output enable, upDown, BCDHex, speed, load, load_val,
        input  count, wrap, cc, an, odp
    );

    modport slave (
        input  enable, upDown, BCDHex, speed, load, load_val,
        output count, wrap, cc, an, odp
    );
endinterface

// File: rtl/updown_counter_display.sv
// Multi-digit BCD/hex up/down counter with rate divider, parallel load and
// a multiplexed active-low seven-segment display driver.
module updown_counter_display #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned PRESCALE_W = 27,
    parameter int unsigned SCAN_BIT   = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    updown_counter_display_if.slave  bus
);
    localparam int unsigned CW   = 4 * DIGITS;
    localparam int unsigned IDXW = 3;

    logic [PRESCALE_W-1:0] div;
    logic                  prev_tap;
    logic                  tap_bit_c;
    logic                  tick_c;
    logic                  mode_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         step_c;
    logic [CW-1:0]         load_sat_c;
    logic                  wrap_q;
    logic                  wrap_c;
    logic [SCAN_BIT-1:0]   scan_div;
    logic [IDXW-1:0]       idx;
    logic [3:0]            digit_c;
    logic [7:0]            an_c;
    logic [7:0]            an_q;
    logic [6:0]            cc_q;
    logic                  odp_q;

    function automatic logic [6:0] seg_font(input logic [3:0] d);
        case (d)
            4'h0: seg_font = 7'b1000000;
            4'h1: seg_font = 7'b1111001;
            4'h2: seg_font = 7'b0100100;
            4'h3: seg_font = 7'b0110000;
            4'h4: seg_font = 7'b0011001;
            4'h5: seg_font = 7'b0010010;
            4'h6: seg_font = 7'b0000010;
            4'h7: seg_font = 7'b1111000;
            4'h8: seg_font = 7'b0000000;
            4'h9: seg_font = 7'b0010000;
            4'hA: seg_font = 7'b0001000;
            4'hB: seg_font = 7'b0000011;
            4'hC: seg_font = 7'b1000110;
            4'hD: seg_font = 7'b0100001;
            4'hE: seg_font = 7'b0000110;
            default: seg_font = 7'b0001110;
        endcase
    endfunction

    // Out-of-range speed falls through to the top divider bit.
    always_comb begin
        tap_bit_c = div[PRESCALE_W-1];
        for (int unsigned i = 0; i < PRESCALE_W; i++) begin
            if (32'(bus.speed) == i) tap_bit_c = div[i];
        end
        tick_c = tap_bit_c & ~prev_tap;
    end

    // Ripple carry/borrow across digits; a carry out of the last digit is a wrap.
    always_comb begin
        logic       carry;
        logic [3:0] d;
        logic [3:0] top;
        step_c = count_q;
        carry  = 1'b1;
        d      = 4'h0;
        top    = bus.BCDHex ? 4'hF : 4'h9;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = count_q[4*i +: 4];
            if (carry) begin
                if (bus.upDown) begin
                    if (d == top) begin
                        step_c[4*i +: 4] = 4'h0;
                    end else begin
                        step_c[4*i +: 4] = d + 4'h1;
                        carry            = 1'b0;
                    end
                end else begin
                    if (d == 4'h0) begin
                        step_c[4*i +: 4] = top;
                    end else begin
                        step_c[4*i +: 4] = d - 4'h1;
                        carry            = 1'b0;
                    end
                end
            end
        end
        wrap_c = carry;
    end

    always_comb begin
        logic [3:0] d;
        load_sat_c = '0;
        d          = 4'h0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = bus.load_val[4*i +: 4];
            load_sat_c[4*i +: 4] = (!bus.BCDHex && (d > 4'h9)) ? 4'h9 : d;
        end
    end

    always_comb begin
        digit_c = count_q[3:0];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == IDXW'(i)) digit_c = count_q[4*i +: 4];
        end
        an_c      = 8'hFF;
        an_c[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            prev_tap <= 1'b0;
            mode_q   <= bus.BCDHex;
            count_q  <= '0;
            wrap_q   <= 1'b0;
            scan_div <= '0;
            idx      <= '0;
            an_q     <= 8'hFE;
            cc_q     <= 7'b1000000;
            odp_q    <= 1'b1;
        end else begin
            div      <= div + PRESCALE_W'(1);
            prev_tap <= tap_bit_c;
            mode_q   <= bus.BCDHex;
            wrap_q   <= 1'b0;
            if (bus.load) begin
                count_q <= load_sat_c;
            end else if (bus.BCDHex != mode_q) begin
                count_q <= '0;
            end else if (tick_c && bus.enable) begin
                count_q <= step_c;
                wrap_q  <= wrap_c;
            end

            scan_div <= scan_div + SCAN_BIT'(1);
            if (&scan_div) begin
                idx <= (idx == IDXW'(DIGITS - 1)) ? '0 : idx + IDXW'(1);
            end
            an_q  <= an_c;
            cc_q  <= seg_font(digit_c);
            odp_q <= ~((idx == '0) && !bus.upDown);
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.an    = an_q;
    assign bus.cc    = cc_q;
    assign bus.odp   = odp_q;
endmodule
